// File: rtl/if_fetch_unit.sv
// ============================================================================
// if_fetch_unit
// ----------------------------------------------------------------------------
// Instruction fetch front end. Issues one-word reads to instruction memory,
// collects the responses in a small FIFO and presents the FIFO head to the ID
// buffer together with PC+1 of that instruction. A redirect from a later stage
// empties the FIFO, reloads the PC, drops any response still in flight and
// flags a flush to the ID buffer for one cycle.
//
// Parameters
//   FETCH_DEPTH  fetch queue entries (2 or 4)
//
// Ports
//   clk          clock, all state updates on the rising edge
//   rst          synchronous active-high reset
//   imem_req     instruction memory read strobe
//   imem_addr    word address of the read (current PC)
//   imem_rdata   instruction word returned one cycle after imem_req
//   imem_rvalid  imem_rdata valid
//   stall        ID hazard hold, head entry is not consumed
//   br_taken     redirect request
//   br_target    redirect PC
//   out_instr    head instruction (zero when out_valid=0)
//   out_pc_next  PC+1 of head instruction (zero when out_valid=0)
//   out_valid    head entry valid
//   out_flush    flush/bubble to the ID buffer
// ============================================================================
module if_fetch_unit #(
    parameter int FETCH_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [5:0]  imem_addr,
    input  logic [15:0] imem_rdata,
    input  logic        imem_rvalid,
    input  logic        stall,
    input  logic        br_taken,
    input  logic [5:0]  br_target,
    output logic [15:0] out_instr,
    output logic [5:0]  out_pc_next,
    output logic        out_valid,
    output logic        out_flush
);

    localparam int PTR_W = $clog2(FETCH_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [PTR_W-1:0] LAST_PTR  = PTR_W'(FETCH_DEPTH - 1);
    localparam logic [CNT_W:0]   DEPTH_OCC = (CNT_W + 1)'(FETCH_DEPTH);

    // 6-bit PC arithmetic wraps 63 -> 0 by construction.
    function automatic logic [5:0] pc_inc(input logic [5:0] pc);
        return pc + 6'd1;
    endfunction

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == LAST_PTR) ? '0 : p + 1'b1;
    endfunction

    logic [5:0]       pc_p0;
    logic             req_vld_p1;
    logic [5:0]       req_pc_next_p1;
    logic [15:0]      q_instr   [FETCH_DEPTH];
    logic [5:0]       q_pc_next [FETCH_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             flush_q;

    logic [CNT_W:0]   occ;
    logic             wr_en;
    logic             rd_en;

    // Stage p0: request issue. Occupancy counts the response already in
    // flight so the queue can never be written while full.
    always_comb begin
        occ       = {1'b0, count} + {{CNT_W{1'b0}}, req_vld_p1};
        imem_req  = !rst && !br_taken && (occ < DEPTH_OCC);
        imem_addr = rst ? 6'd0 : pc_p0;
    end

    // Stage p1: response capture and head consumption. A redirect in the same
    // cycle wins over both, which also discards the response arriving now.
    always_comb begin
        out_valid   = !rst && (count != '0);
        out_instr   = out_valid ? q_instr[rd_ptr]   : 16'h0000;
        out_pc_next = out_valid ? q_pc_next[rd_ptr] : 6'd0;
        out_flush   = rst || flush_q;
        wr_en       = imem_rvalid && req_vld_p1 && !br_taken && !rst;
        rd_en       = out_valid && !stall && !br_taken;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_p0      <= 6'd0;
            req_vld_p1 <= 1'b0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            flush_q    <= 1'b0;
        end else if (br_taken) begin
            pc_p0      <= br_target;
            req_vld_p1 <= 1'b0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            flush_q    <= 1'b1;
        end else begin
            flush_q    <= 1'b0;
            req_vld_p1 <= imem_req;
            if (imem_req) begin
                pc_p0 <= pc_inc(pc_p0);
            end
            if (wr_en) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (rd_en) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            case ({wr_en, rd_en})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (imem_req) begin
            req_pc_next_p1 <= pc_inc(pc_p0);
        end
        if (wr_en) begin
            q_instr[wr_ptr]   <= imem_rdata;
            q_pc_next[wr_ptr] <= req_pc_next_p1;
        end
    end

endmodule

// File: tb/tb_if_fetch_unit.sv
// ============================================================================
// tb_if_fetch_unit
// ----------------------------------------------------------------------------
// Bench for if_fetch_unit (FETCH_DEPTH=2). A one-cycle-latency memory model
// answers each read; expected head entries are queued by the stimulus process
// and a negedge monitor compares every presented head against the queue front,
// popping it when the head is consumed. Directed checks cover reset, latency,
// stall back-pressure, redirects, PC wrap and stale-response dropping.
// ============================================================================
module tb_if_fetch_unit;

    typedef struct packed {
        logic [15:0] instr;
        logic [5:0]  pcn;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_req;
    logic [5:0]  imem_addr;
    logic [15:0] imem_rdata = 16'h0000;
    logic        imem_rvalid = 1'b0;
    logic        stall = 1'b0;
    logic        br_taken = 1'b0;
    logic [5:0]  br_target = 6'd0;
    logic [15:0] out_instr;
    logic [5:0]  out_pc_next;
    logic        out_valid;
    logic        out_flush;
    logic        spur = 1'b0;

    int   errors = 0;
    int   checks = 0;
    int   pops   = 0;
    exp_t exp_q[$];

    if_fetch_unit #(.FETCH_DEPTH(2)) dut (
        .clk        (clk),
        .rst        (rst),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_rdata (imem_rdata),
        .imem_rvalid(imem_rvalid),
        .stall      (stall),
        .br_taken   (br_taken),
        .br_target  (br_target),
        .out_instr  (out_instr),
        .out_pc_next(out_pc_next),
        .out_valid  (out_valid),
        .out_flush  (out_flush)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] mem_word(input logic [5:0] a);
        case (a)
            6'd0:    return 16'h0564;
            6'd1:    return 16'h0155;
            default: return 16'hA000 + {10'd0, a};
        endcase
    endfunction

    // Memory: data one cycle after the request; spur injects an unsolicited
    // response carrying garbage.
    always @(posedge clk) begin
        imem_rvalid <= imem_req | spur;
        imem_rdata  <= spur ? 16'hDEAD : mem_word(imem_addr);
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic push_stream(input logic [5:0] start, input int n);
        logic [5:0] a;
        exp_q.delete();
        a = start;
        for (int i = 0; i < n; i++) begin
            exp_q.push_back('{instr: mem_word(a), pcn: a + 6'd1});
            a = a + 6'd1;
        end
    endtask

    // Monitor: compare every presented head, pop when it is consumed.
    always @(negedge clk) begin
        if (out_valid) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL mon_unexpected: got %h/%0d expected no entry", out_instr, out_pc_next);
            end else begin
                if ({out_instr, out_pc_next} !== exp_q[0]) begin
                    errors++;
                    $display("FAIL mon_head: got %h/%0d expected %h/%0d",
                             out_instr, out_pc_next, exp_q[0].instr, exp_q[0].pcn);
                end
                if (!stall && !br_taken) begin
                    void'(exp_q.pop_front());
                    pops++;
                end
            end
        end
    end

    initial begin
        repeat (3) tick();
        #1;
        chk("rst_valid", {15'd0, out_valid}, 16'd0);
        chk("rst_flush", {15'd0, out_flush}, 16'd1);
        chk("rst_req",   {15'd0, imem_req},  16'd0);
        chk("rst_addr",  {10'd0, imem_addr}, 16'd0);
        chk("rst_instr", out_instr,          16'h0000);
        chk("rst_pcn",   {10'd0, out_pc_next}, 16'd0);

        // C0: first cycle after reset release
        tick(); rst = 1'b0; push_stream(6'd0, 20); #1;
        chk("c0_req",   {15'd0, imem_req},  16'd1);
        chk("c0_addr",  {10'd0, imem_addr}, 16'd0);
        chk("c0_flush", {15'd0, out_flush}, 16'd0);
        chk("c0_valid", {15'd0, out_valid}, 16'd0);
        tick(); #1;  // C1
        chk("c1_addr",  {10'd0, imem_addr}, 16'd1);
        chk("c1_valid", {15'd0, out_valid}, 16'd0);
        tick(); #1;  // C2
        chk("c2_valid", {15'd0, out_valid}, 16'd1);
        chk("c2_instr", out_instr,          16'h0564);
        chk("c2_pcn",   {10'd0, out_pc_next}, 16'd1);
        tick(); #1;  // C3
        chk("c3_instr", out_instr,          16'h0155);
        chk("c3_pcn",   {10'd0, out_pc_next}, 16'd2);
        tick(); tick();  // C4, C5

        // Stall C6..C10
        tick(); stall = 1'b1;  // C6
        tick(); tick(); #1;    // C8
        chk("stall_req_c8", {15'd0, imem_req}, 16'd0);
        tick(); #1;            // C9
        chk("stall_req_c9", {15'd0, imem_req}, 16'd0);
        tick(); #1;            // C10
        chk("stall_req_c10", {15'd0, imem_req}, 16'd0);
        chk("stall_head",    out_instr,         16'hA003);
        tick(); stall = 1'b0; #1;  // C11
        chk("unstall_req_c11", {15'd0, imem_req}, 16'd0);
        tick(); #1;            // C12
        chk("resume_req",  {15'd0, imem_req},  16'd1);
        chk("resume_addr", {10'd0, imem_addr}, 16'd5);
        tick();                // C13

        // Redirect to 40 with an entry queued and a response in flight
        tick(); br_taken = 1'b1; br_target = 6'd40; #1;  // C14
        chk("br_req", {15'd0, imem_req}, 16'd0);
        tick(); br_taken = 1'b0; push_stream(6'd40, 20); #1;  // C15
        chk("br40_flush", {15'd0, out_flush}, 16'd1);
        chk("br40_valid", {15'd0, out_valid}, 16'd0);
        chk("br40_instr", out_instr,          16'h0000);
        chk("br40_pcn",   {10'd0, out_pc_next}, 16'd0);
        chk("br40_req",   {15'd0, imem_req},  16'd1);
        chk("br40_addr",  {10'd0, imem_addr}, 16'd40);
        tick(); #1;  // C16
        chk("br40_flush_off", {15'd0, out_flush}, 16'd0);
        tick(); #1;  // C17
        chk("br40_first_valid", {15'd0, out_valid},   16'd1);
        chk("br40_first_pcn",   {10'd0, out_pc_next}, 16'd41);

        // Back-to-back redirects: 10 then 63, latest wins
        tick(); br_taken = 1'b1; br_target = 6'd10;  // C18
        tick(); br_target = 6'd63; push_stream(6'd10, 4); #1;  // C19
        chk("br2_flush", {15'd0, out_flush}, 16'd1);
        chk("br2_valid", {15'd0, out_valid}, 16'd0);
        tick(); br_taken = 1'b0; push_stream(6'd63, 20); #1;  // C20
        chk("br63_flush", {15'd0, out_flush}, 16'd1);
        chk("br63_addr",  {10'd0, imem_addr}, 16'd63);
        tick(); #1;  // C21
        chk("wrap_req",  {15'd0, imem_req},  16'd1);
        chk("wrap_addr", {10'd0, imem_addr}, 16'd0);
        tick(); stall = 1'b1; #1;  // C22
        chk("wrap_valid", {15'd0, out_valid},   16'd1);
        chk("wrap_instr", out_instr,            16'hA03F);
        chk("wrap_pcn",   {10'd0, out_pc_next}, 16'd0);
        tick(); #1;  // C23: queue full under stall
        chk("full_valid", {15'd0, out_valid}, 16'd1);
        chk("full_req",   {15'd0, imem_req},  16'd0);

        // Redirect while stalled with a full queue
        tick(); br_taken = 1'b1; br_target = 6'd20;  // C24
        tick(); br_taken = 1'b0; stall = 1'b0; push_stream(6'd20, 20); #1;  // C25
        chk("brst_flush", {15'd0, out_flush}, 16'd1);
        chk("brst_valid", {15'd0, out_valid}, 16'd0);
        chk("brst_addr",  {10'd0, imem_addr}, 16'd20);
        tick();                    // C26
        tick(); spur = 1'b1;       // C27: unsolicited response lands in C28
        tick(); spur = 1'b0;       // C28
        tick();                    // C29

        // One-cycle reset pulse; unsolicited response right after release
        tick(); rst = 1'b1; spur = 1'b1; #1;  // C30
        chk("prst_valid", {15'd0, out_valid}, 16'd0);
        chk("prst_flush", {15'd0, out_flush}, 16'd1);
        chk("prst_req",   {15'd0, imem_req},  16'd0);
        chk("prst_addr",  {10'd0, imem_addr}, 16'd0);
        tick(); rst = 1'b0; spur = 1'b0; push_stream(6'd0, 20); #1;  // C31
        chk("prst_c31_req",   {15'd0, imem_req},  16'd1);
        chk("prst_c31_addr",  {10'd0, imem_addr}, 16'd0);
        chk("prst_c31_flush", {15'd0, out_flush}, 16'd0);
        tick(); #1;  // C32
        chk("prst_c32_valid", {15'd0, out_valid}, 16'd0);
        tick(); #1;  // C33
        chk("prst_c33_valid", {15'd0, out_valid},   16'd1);
        chk("prst_c33_instr", out_instr,            16'h0564);
        chk("prst_c33_pcn",   {10'd0, out_pc_next}, 16'd1);

        repeat (10) tick();
        checks++;
        if (pops < 8) begin
            errors++;
            $display("FAIL consumed_entries: got %0d expected at least 8", pops);
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
